// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the dot-product accumulator.
// State encoding and product width used by the top and the adder.
package dot_acc_pkg;

    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/dot_acc_sat_add.sv
// Signed accumulate-add of one product; clamps on overflow when the
// DOT_ACC_SATURATE_EN macro is defined, otherwise wraps.
module dot_acc_sat_add
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;

    assign ext = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    assign raw = acc_i + ext;

`ifdef DOT_ACC_SATURATE_EN
    logic             ovf_raw;
    logic [ACC_W-1:0] pos_max;
    logic [ACC_W-1:0] neg_min;

    assign pos_max = {1'b0, {(ACC_W-1){1'b1}}};
    assign neg_min = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow only when both operands share a sign the result lacks.
    assign ovf_raw = (acc_i[ACC_W-1] == ext[ACC_W-1])
                  && (raw[ACC_W-1] != acc_i[ACC_W-1]);

    always_comb begin
        sum_o = raw;
        if (ovf_raw) begin
            sum_o = acc_i[ACC_W-1] ? neg_min : pos_max;
        end
    end

    assign ovf_o = ovf_raw;
`else
    assign sum_o = raw;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates N signed products into one dot-product result with a
// valid/ready result handshake. Optional macro: DOT_ACC_SATURATE_EN.
module dot_accumulator
    import dot_acc_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic              busy_o,
    output logic              ovf_o
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic             prod_hs;
    logic             sum_hs;
    logic [ACC_W-1:0] add_base;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;

    assign prod_ready_o = (state_q != HOLD);
    assign busy_o       = (state_q != IDLE);
    assign sum_valid_o  = (state_q == HOLD);
    assign sum_o        = sum_q;
    assign ovf_o        = ovf_q;

    assign prod_hs = prod_valid_i && prod_ready_o;
    assign sum_hs  = sum_valid_o && sum_ready_i;

    // First product of a run starts from zero regardless of acc_q.
    assign add_base = (state_q == IDLE) ? '0 : acc_q;
    assign cnt_inc  = ((state_q == IDLE) ? '0 : cnt_q) + CNT_W'(1);

    dot_acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i  (add_base),
        .prod_i (prod_i),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (prod_hs) begin
                        acc_d   = add_sum;
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf_q | add_ovf;
                        state_d = ACCUM;
                        if (cnt_inc == N_C) begin
                            sum_d   = add_sum;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (sum_hs) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: three instances (N=4/W=20,
// N=8/W=20, N=4/W=17) share stimulus; each test checks one of them.
module tb_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [15:0] prod;
    logic        pvalid;
    logic        sready;

    logic               a_prdy, a_sval, a_busy, a_ovf;
    logic signed [19:0] a_sum;
    logic               b_prdy, b_sval, b_busy, b_ovf;
    logic signed [19:0] b_sum;
    logic               c_prdy, c_sval, c_busy, c_ovf;
    logic signed [16:0] c_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dot_accumulator #(.N(4), .ACC_W(20)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .prod_i       (prod),
        .prod_valid_i (pvalid),
        .prod_ready_o (a_prdy),
        .sum_o        (a_sum),
        .sum_valid_o  (a_sval),
        .sum_ready_i  (sready),
        .busy_o       (a_busy),
        .ovf_o        (a_ovf)
    );

    dot_accumulator #(.N(8), .ACC_W(20)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .prod_i       (prod),
        .prod_valid_i (pvalid),
        .prod_ready_o (b_prdy),
        .sum_o        (b_sum),
        .sum_valid_o  (b_sval),
        .sum_ready_i  (sready),
        .busy_o       (b_busy),
        .ovf_o        (b_ovf)
    );

    dot_accumulator #(.N(4), .ACC_W(17)) dut_c (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .prod_i       (prod),
        .prod_valid_i (pvalid),
        .prod_ready_o (c_prdy),
        .sum_o        (c_sum),
        .sum_valid_o  (c_sval),
        .sum_ready_i  (sready),
        .busy_o       (c_busy),
        .ovf_o        (c_ovf)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p);
        pvalid = 1'b1;
        prod   = 16'(p);
        tick();
    endtask

    task automatic nop();
        pvalid = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        pvalid = 1'b0;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        clear  = 1'b0;
        prod   = '0;
        pvalid = 1'b0;
        sready = 1'b1;
        #2;
        chk("rst_sum",   a_sum,  0);
        chk("rst_sval",  a_sval, 0);
        chk("rst_busy",  a_busy, 0);
        chk("rst_prdy",  a_prdy, 1);
        chk("rst_ovf",   a_ovf,  0);
        rst = 1'b0;
        tick();

        // basic 4-product sum, one-cycle valid pulse
        do_clear();
        push(100);
        chk("b1_busy", a_busy, 1);
        push(-50);
        push(25);
        chk("b1_sval_early", a_sval, 0);
        push(-1);
        pvalid = 1'b0;
        chk("b1_sval", a_sval, 1);
        chk("b1_sum",  a_sum,  74);
        chk("b1_prdy", a_prdy, 0);
        nop();
        chk("b1_sval_drop", a_sval, 0);
        chk("b1_busy_idle", a_busy, 0);
        chk("b1_prdy_idle", a_prdy, 1);

        // back-pressure in HOLD
        do_clear();
        sready = 1'b0;
        push(10);
        push(20);
        push(30);
        push(40);
        chk("bp_sum", a_sum, 100);
        for (int i = 0; i < 5; i++) begin
            pvalid = (i == 2);
            prod   = 16'd999;
            tick();
            chk("bp_hold_sum",  a_sum,  100);
            chk("bp_hold_sval", a_sval, 1);
            chk("bp_hold_prdy", a_prdy, 0);
        end
        pvalid = 1'b0;
        sready = 1'b1;
        tick();
        chk("bp_drain_sval", a_sval, 0);
        chk("bp_drain_busy", a_busy, 0);
        push(1);
        push(1);
        push(1);
        push(1);
        pvalid = 1'b0;
        chk("bp_next_sum",  a_sum,  4);
        chk("bp_next_sval", a_sval, 1);
        nop();

        // abort via clear_i
        push(5);
        push(6);
        do_clear();
        chk("clr_busy", a_busy, 0);
        chk("clr_sval", a_sval, 0);
        chk("clr_keep", a_sum,  4);
        push(1);
        push(2);
        push(3);
        push(4);
        pvalid = 1'b0;
        chk("clr_sum",  a_sum,  10);
        chk("clr_sval2", a_sval, 1);
        nop();

        // reset in the middle of accumulation
        do_clear();
        push(1);
        push(2);
        push(3);
        pvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_sum",  a_sum,  0);
        chk("mrst_sval", a_sval, 0);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_prdy", a_prdy, 1);
        chk("mrst_ovf",  a_ovf,  0);
        rst = 1'b0;
        tick();
        push(1);
        push(1);
        push(1);
        push(1);
        pvalid = 1'b0;
        chk("mrst_sum2",  a_sum,  4);
        chk("mrst_sval2", a_sval, 1);
        nop();

        // N=8 largest products
        do_clear();
        for (int i = 0; i < 7; i++) begin
            push(16384);
        end
        chk("n8_sval_early", b_sval, 0);
        push(16384);
        pvalid = 1'b0;
        chk("n8_sval", b_sval, 1);
        chk("n8_sum",  b_sum,  131072);
        chk("n8_ovf",  b_ovf,  0);
        nop();

        // ACC_W=17 overflow behaviour
        do_clear();
        push(16384);
        push(16384);
        push(16384);
        chk("w17_ovf_early", c_ovf, 0);
        push(16384);
        pvalid = 1'b0;
        chk("w17_sval", c_sval, 1);
`ifdef DOT_ACC_SATURATE_EN
        chk("w17_sum", c_sum, 65535);
        chk("w17_ovf", c_ovf, 1);
`else
        chk("w17_sum", c_sum, -65536);
        chk("w17_ovf", c_ovf, 0);
`endif
        nop();
        chk("w17_ovf_clr",  c_ovf,  0);
        chk("w17_sval_clr", c_sval, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dot_accumulator.md
DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 SHALL have parameter N, default 8: number of products per dot-product (legal 2..64).
REQ-002 SHALL have parameter ACC_W, default 20: signed accumulator and result width (legal 17..32).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear_i  input  1  synchronous abort of the current dot-product.
REQ-006 SHALL have port prod_i  input  16  signed product from the 8x8 signed multiplier.
REQ-007 SHALL have port prod_valid_i  input  1  prod_i holds a new product.
REQ-008 SHALL have port prod_ready_o  output  1  block can accept a product this cycle.
REQ-009 SHALL have port sum_o  output  ACC_W  signed completed dot-product.
REQ-010 SHALL have port sum_valid_o  output  1  sum_o is valid.
REQ-011 SHALL have port sum_ready_i  input  1  consumer takes sum_o.
REQ-012 SHALL have port busy_o  output  1  at least one product accumulated, result not yet delivered.
REQ-013 SHALL have port ovf_o  output  1  sticky: current dot-product saturated.

Function
REQ-014 SHALL implement states IDLE, ACCUM, HOLD.
REQ-015 Product handshake SHALL occur when prod_valid_i and prod_ready_o are both high at a rising edge.
REQ-016 prod_ready_o SHALL be high in IDLE and ACCUM, low in HOLD.
REQ-017 IDLE: on handshake, acc <= sign-extended prod_i, count <= 1, go to ACCUM.
REQ-018 ACCUM: on handshake, acc <= acc + sign-extended prod_i, count <= count + 1.
REQ-019 On the handshake making count equal N, the final sum SHALL be loaded into sum_o, sum_valid_o set, and the state SHALL go to HOLD; sum_valid_o rises the cycle after the Nth handshake.
REQ-020 Cycles without a handshake SHALL leave acc and count unchanged (no timeout).
REQ-021 HOLD: sum_o and sum_valid_o SHALL stay stable until sum_valid_o and sum_ready_i are both high.
REQ-022 On the result handshake: state to IDLE, sum_valid_o cleared, acc and count cleared, ovf_o cleared; no product is accepted in that cycle.
REQ-023 clear_i SHALL override all other activity: state IDLE, acc, count, sum_valid_o and ovf_o to 0; a product presented in the same cycle is discarded; sum_o keeps its last value.
REQ-024 busy_o SHALL be high in ACCUM and HOLD, low in IDLE.
REQ-025 Arithmetic SHALL be two's-complement signed at ACC_W bits.

Reset
REQ-026 rst SHALL force state IDLE, acc 0, count 0, sum_o 0, sum_valid_o 0, ovf_o 0, busy_o 0; prod_ready_o SHALL be 1 while in IDLE.
REQ-027 Reset asserted mid-accumulation or in HOLD SHALL discard the partial result.

Configuration
REQ-028 With macro DOT_ACC_SATURATE_EN defined, each add SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on signed overflow and set ovf_o until the result handshake, clear_i, or rst.
REQ-029 Without DOT_ACC_SATURATE_EN, adds SHALL wrap modulo 2^ACC_W and ovf_o SHALL be tied 0.

Structure
REQ-030 State encoding (IDLE=2'b00, ACCUM=2'b01, HOLD=2'b10) and the product width constant 16 SHALL live in shared package dot_acc_pkg.
REQ-031 The add/clamp path SHALL be sub-module dot_acc_sat_add (ACC_W parameter; inputs acc and product; outputs sum and overflow), instantiated once.
REQ-032 The count width SHALL be $clog2(N+1).

Verification
REQ-033 N=4: products 100, -50, 25, -1, one per cycle, sum_ready_i=1 -> sum_o=74, sum_valid_o high for exactly 1 cycle, 1 cycle after the 4th handshake.
REQ-034 N=8: eight products of -128*-128=16384 -> sum_o=131072, ovf_o=0.
REQ-035 N=4: sum_ready_i=0 for 5 cycles after the result -> sum_o stable, prod_ready_o=0, a prod_valid_i pulse in HOLD is ignored; the next dot-product starts from 0.
REQ-036 N=4: two products, then clear_i, then products 1, 2, 3, 4 -> sum_o=10.
REQ-037 ACC_W=17, N=4, DOT_ACC_SATURATE_EN: four products of 16384 -> sum_o=65535, ovf_o=1; without the macro -> sum_o=-65536, ovf_o=0.
REQ-038 rst pulsed after the 3rd of N=4 products -> all outputs are at reset values; the next four products of 1 give sum_o=4.
